multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port part_of_inst, input, 7 bits: opcode field from the instruction register, stable from ID onward; opcodes per opcodes.v.
REQ-004 SHALL have port alu_bcond, input, 1 bit: branch condition from the ALU, valid in EX.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL have port halt_req, input, 1 bit: ecall halt condition from the register file (x17==10).
REQ-007 SHALL have outputs pc_write (1), i_or_d (1), mem_read (1), mem_write (1), ir_write (1), mem_to_reg (1), reg_write (1) and pc_to_reg (1).
REQ-008 SHALL have outputs alu_src_a (1; 0=PC, 1=rs1) and alu_src_b (2; 00=rs2, 01=4, 10=imm).
REQ-009 SHALL have output alu_op (2; 00=add, 01=branch compare, 10=funct-decoded).
REQ-010 SHALL have output pc_source (2; 00=PC+4 adder, 01=ALUOut register, 10=live ALU result).
REQ-011 SHALL have outputs halted (1) and state (3, debug).

Function
REQ-012 SHALL use states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, held in one 3-bit register; outputs are combinational from state, part_of_inst, alu_bcond and mem_ready.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 IF SHALL assert mem_read=1, i_or_d=0 and ir_write=mem_ready; it SHALL move to ID when mem_ready=1, else stay in IF.
REQ-015 ID SHALL drive alu_src_a=0, alu_src_b=10, alu_op=00, so that ALUOut <= PC+imm.
REQ-016 ID for ECALL: halt_req=1 SHALL go to HALT; halt_req=0 SHALL assert pc_write with pc_source=00 and go to IF.
REQ-017 ID for any other opcode SHALL go to EX.
REQ-018 EX for ARITHMETIC SHALL drive a=1, b=00, op=10 and go to WB.
REQ-019 EX for ARITHMETIC_IMM SHALL drive a=1, b=10, op=10 and go to WB.
REQ-020 EX for LOAD/STORE SHALL drive a=1, b=10, op=00 and go to MEM.
REQ-021 EX for BRANCH SHALL drive a=1, b=00, op=01, pc_write=1, pc_source = alu_bcond ? 01 : 00, and go to IF.
REQ-022 EX for JAL SHALL assert reg_write=1, pc_to_reg=1, pc_write=1, pc_source=01 and go to IF.
REQ-023 EX for JALR SHALL drive a=1, b=10, op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=10 and go to IF.
REQ-024 EX for any unlisted opcode SHALL be a NOP: pc_write=1, pc_source=00, go to IF.
REQ-025 MEM SHALL assert i_or_d=1, plus mem_read=1 for LOAD or mem_write=1 for STORE, held every cycle until mem_ready=1.
REQ-026 MEM with mem_ready=1 SHALL go to WB for LOAD, or assert pc_write=1, pc_source=00 and go to IF for STORE; with mem_ready=0 it SHALL stay in MEM.
REQ-027 WB SHALL assert reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, pc_source=00 and go to IF.
REQ-028 HALT SHALL assert halted=1 with all enables 0, and SHALL stay in HALT until reset.
REQ-029 pc_write, reg_write and mem_write SHALL each pulse for at most one cycle per instruction.
REQ-030 Instruction latency with zero wait states SHALL be: R/I-type 4 cycles, load 5, store 4, branch/jal/jalr 3, ecall 2.

Reset
REQ-031 reset_n=0 SHALL force state=IF immediately, without waiting for clk.
REQ-032 While reset_n=0, all enables, halted and all select outputs SHALL be 0.
REQ-033 An instruction in flight at reset SHALL be abandoned; the first fetch begins on the first clk edge after reset_n rises.

Verification
REQ-034 ARITHMETIC (0110011), mem_ready=1 -> states 0,1,2,4,0; reg_write=1 and pc_write=1 only in WB with pc_source=00.
REQ-035 LOAD (0000011), mem_ready=0 for the first 2 MEM cycles -> MEM lasts 3 cycles with mem_read=1, i_or_d=1 held, then WB with mem_to_reg=1.
REQ-036 BRANCH (1100011) -> alu_bcond=1 gives pc_source=01 in EX; alu_bcond=0 gives 00; pc_write=1 in EX in both cases, next state IF.
REQ-037 ECALL (1110011) -> halt_req=1: HALT, halted=1 and no enables for 10+ cycles; halt_req=0: pc_write=1 with pc_source=00 in ID, then IF.
REQ-038 STORE (0100011) with reset_n dropped mid-MEM and mem_ready=0 -> mem_write falls to 0 without a clk edge, state=0, and IF resumes after release.
REQ-039 Opcode 0000000 -> states 0,1,2,0 with only pc_write=1 and pc_source=00 in EX.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - multi-cycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT)
//
// Purpose: sequences one instruction through fetch, decode, execute, memory
// and write-back, driving datapath enables and mux selects combinationally
// from the current state and the instruction opcode.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset_n      in   1  asynchronous active-low reset
//   part_of_inst in   7  opcode field, stable from ID onward
//   alu_bcond    in   1  branch condition, valid in EX
//   mem_ready    in   1  memory completes the current access this cycle
//   halt_req     in   1  ecall halt condition (x17 == 10)
//   pc_write, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, pc_to_reg       out 1  datapath enables/selects
//   alu_src_a    out  1  0=PC, 1=rs1
//   alu_src_b    out  2  00=rs2, 01=4, 10=imm
//   alu_op       out  2  00=add, 01=branch compare, 10=funct-decoded
//   pc_source    out  2  00=PC+4, 01=ALUOut, 10=live ALU result
//   halted       out  1  processor stopped on ecall
//   state        out  3  current state, for debug
module multi_cycle_control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] part_of_inst,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       pc_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic [2:0] state
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    halted     = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_d = S_ID;
      end

      S_ID: begin
        // Precompute PC+imm into ALUOut for branch/jal targets.
        alu_src_b = 2'b10;
        if (part_of_inst == OP_ECALL) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        case (part_of_inst)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_write  = 1'b1;
            pc_source = alu_bcond ? 2'b01 : 2'b00;
            state_d   = S_IF;
          end
          OP_JAL: begin
            // Target was computed into ALUOut during ID.
            reg_write = 1'b1;
            pc_to_reg = 1'b1;
            pc_write  = 1'b1;
            pc_source = 2'b01;
            state_d   = S_IF;
          end
          OP_JALR: begin
            // rs1+imm is taken straight from the ALU this cycle.
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            reg_write = 1'b1;
            pc_to_reg = 1'b1;
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_IF;
          end
          default: begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        endcase
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (part_of_inst == OP_LOAD);
        mem_write = (part_of_inst == OP_STORE);
        if (mem_ready) begin
          if (part_of_inst == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (part_of_inst == OP_LOAD);
        pc_write   = 1'b1;
        state_d    = S_IF;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IF;
      end
    endcase

    // Outputs are combinational, so reset must mask them directly.
    if (!reset_n) begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_to_reg  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - directed vector bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

  localparam logic [6:0] ARI  = 7'b0110011;
  localparam logic [6:0] ARII = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECL  = 7'b1110011;
  localparam logic [6:0] NOP  = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] part_of_inst;
  logic       alu_bcond, mem_ready, halt_req;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, pc_to_reg, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  multi_cycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .part_of_inst(part_of_inst),
    .alu_bcond(alu_bcond), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // Packed control word:
  // {pcw, iod, mr, mw, irw, m2r, rw, p2r, a, b[1:0], op[1:0], ps[1:0], halted}
  function automatic logic [15:0] mk(input logic pcw, input logic iod, input logic mr,
                                     input logic mw, input logic irw, input logic m2r,
                                     input logic rw, input logic p2r, input logic a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] ps, input logic h);
    return {pcw, iod, mr, mw, irw, m2r, rw, p2r, a, b, op, ps, h};
  endfunction

  function automatic logic [15:0] ctl_now();
    return {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
            pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, halted};
  endfunction

  typedef struct {
    logic [6:0]  opc;
    logic        bc;
    logic        mrdy;
    logic        hreq;
    logic [2:0]  exp_state;
    logic [15:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] opc, input logic bc, input logic mrdy,
                     input logic hreq, input logic [2:0] st, input logic [15:0] ctl);
    vec_t v;
    v.opc = opc; v.bc = bc; v.mrdy = mrdy; v.hreq = hreq;
    v.exp_state = st; v.exp_ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [15:0] ctl);
    checks++;
    if (state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, state, st);
    end
    checks++;
    if (ctl_now() !== ctl) begin
      errors++;
      $display("FAIL %s ctl: got %h expected %h", name, ctl_now(), ctl);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic bc, input logic mrdy, input logic hreq);
    part_of_inst = opc; alu_bcond = bc; mem_ready = mrdy; halt_req = hreq;
  endtask

  logic [15:0] c_zero, c_if, c_if_w, c_id, c_id_pc, c_pc4, c_halt;

  initial begin
    c_zero  = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_if    = mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_if_w  = mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_id    = mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0);
    c_id_pc = mk(1,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0);
    c_pc4   = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    c_halt  = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);

    // ARITHMETIC, zero wait states: 0,1,2,4
    add(ARI, 0, 1, 0, 3'd0, c_if_w);
    add(ARI, 0, 1, 0, 3'd1, c_id);
    add(ARI, 0, 1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0));
    add(ARI, 0, 1, 0, 3'd4, mk(1,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0));
    // LOAD with one IF wait and two MEM waits
    add(LD, 0, 0, 0, 3'd0, c_if);
    add(LD, 0, 1, 0, 3'd0, c_if_w);
    add(LD, 0, 1, 0, 3'd1, c_id);
    add(LD, 0, 1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    add(LD, 0, 0, 0, 3'd3, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    add(LD, 0, 0, 0, 3'd3, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    add(LD, 0, 1, 0, 3'd3, mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    add(LD, 0, 1, 0, 3'd4, mk(1,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0));
    // BRANCH taken then not taken
    add(BR, 1, 1, 0, 3'd0, c_if_w);
    add(BR, 1, 1, 0, 3'd1, c_id);
    add(BR, 1, 1, 0, 3'd2, mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0));
    add(BR, 0, 1, 0, 3'd0, c_if_w);
    add(BR, 0, 1, 0, 3'd1, c_id);
    add(BR, 0, 1, 0, 3'd2, mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b00,0));
    // JAL, JALR
    add(JAL, 0, 1, 0, 3'd0, c_if_w);
    add(JAL, 0, 1, 0, 3'd1, c_id);
    add(JAL, 0, 1, 0, 3'd2, mk(1,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b01,0));
    add(JALR, 0, 1, 0, 3'd0, c_if_w);
    add(JALR, 0, 1, 0, 3'd1, c_id);
    add(JALR, 0, 1, 0, 3'd2, mk(1,0,0,0,0,0,1,1,1,2'b10,2'b00,2'b10,0));
    // ARITHMETIC_IMM
    add(ARII, 0, 1, 0, 3'd0, c_if_w);
    add(ARII, 0, 1, 0, 3'd1, c_id);
    add(ARII, 0, 1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0));
    add(ARII, 0, 1, 0, 3'd4, mk(1,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0));
    // STORE with one MEM wait
    add(ST, 0, 1, 0, 3'd0, c_if_w);
    add(ST, 0, 1, 0, 3'd1, c_id);
    add(ST, 0, 1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    add(ST, 0, 0, 0, 3'd3, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    add(ST, 0, 1, 0, 3'd3, mk(1,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    // Unlisted opcode acts as NOP
    add(NOP, 0, 1, 0, 3'd0, c_if_w);
    add(NOP, 0, 1, 0, 3'd1, c_id);
    add(NOP, 0, 1, 0, 3'd2, c_pc4);
    // ECALL without halt, then with halt
    add(ECL, 0, 1, 0, 3'd0, c_if_w);
    add(ECL, 0, 1, 0, 3'd1, c_id_pc);
    add(ECL, 0, 1, 1, 3'd0, c_if_w);
    add(ECL, 0, 1, 1, 3'd1, c_id);
    add(ECL, 0, 1, 1, 3'd5, c_halt);

    drive(ARI, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #12;
    check("reset", 3'd0, c_zero);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].opc, vecs[i].bc, vecs[i].mrdy, vecs[i].hreq);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctl);
      @(posedge clk);
      #1;
    end

    // HALT holds regardless of inputs until reset
    for (int k = 0; k < 12; k++) begin
      drive(vecs[k % 8].opc, k[0], k[1], k[2]);
      #1;
      check($sformatf("halt%0d", k), 3'd5, c_halt);
      @(posedge clk);
      #1;
    end

    // Reset leaves HALT without a clock edge
    reset_n = 1'b0;
    #1;
    check("halt_reset", 3'd0, c_zero);
    @(negedge clk);
    reset_n = 1'b1;

    // STORE abandoned by reset mid-MEM
    drive(ST, 0, 1, 0);
    #1; check("st_if", 3'd0, c_if_w);
    @(posedge clk); #1;
    check("st_id", 3'd1, c_id);
    @(posedge clk); #1;
    check("st_ex", 3'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1; check("st_mem", 3'd3, mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
    #1; reset_n = 1'b0;
    #1; check("st_async_rst", 3'd0, c_zero);
    @(posedge clk); #1;
    check("st_rst_held", 3'd0, c_zero);
    @(negedge clk);
    reset_n = 1'b1;
    #1; check("st_release", 3'd0, c_if);
    @(posedge clk); #1;
    check("st_if_wait", 3'd0, c_if);
    mem_ready = 1'b1;
    #1; check("st_refetch", 3'd0, c_if_w);
    @(posedge clk); #1;
    check("st_redecode", 3'd1, c_id);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
